seg7_count_monitor: RTL and testbench
=====================================

Name: seg7_count_monitor

Overview:
- Receiving end of the 7-segment display interface driven by the team's display counters (e.g. the 2-bit count-up counter).
- Samples the seven segment lines a..g, filters glitches, and decodes the stable pattern back to a binary digit.
- Classifies each digit change as an up-step, a down-step or a skip, and keeps saturating step counts.
- Used as an in-system checker and as a self-checking bench component for display counters.

Parameters:
MODULUS, 4, count modulus of the observed counter; legal range 2..16; valid digits are 0..MODULUS-1
STABLE_CYCLES, 2, consecutive identical samples needed before a pattern is accepted; legal range 1..15
CNT_W, 8, width of the up/down step counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
a  input  1  segment a, active-high
b  input  1  segment b, active-high
c  input  1  segment c, active-high
d  input  1  segment d, active-high
e  input  1  segment e, active-high
f  input  1  segment f, active-high
g  input  1  segment g, active-high
digit  output  4  last accepted valid digit
digit_valid  output  1  1 while digit reflects the currently accepted pattern
step_up  output  1  1-cycle pulse: accepted digit = (previous+1) mod MODULUS
step_down  output  1  1-cycle pulse: accepted digit = (previous-1) mod MODULUS
skip_err  output  1  1-cycle pulse: accepted digit is neither up nor down from previous
bad_pattern  output  1  1-cycle pulse: stable pattern not a legal digit
fault  output  1  sticky: set on skip_err or bad_pattern
up_cnt  output  CNT_W  step_up count, saturating at all-ones
down_cnt  output  CNT_W  step_down count, saturating at all-ones

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While reset=0, all registers clear: digit=0, digit_valid=0, all pulses=0, fault=0, up_cnt=0, down_cnt=0, state=WAIT, sample register=0000000, stability counter=0.
- Input sampling: {a,b,c,d,e,f,g} is registered every edge into seg_q.
  - The stability counter resets to 1 when seg_q changes and increments (saturating) while seg_q is unchanged.
  - A pattern is stable when the counter reaches STABLE_CYCLES.
- Decode table ({a..g}, hex digit): 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9, 1110111=A, 0011111=b, 1001110=C, 0111101=d, 1001111=E, 1000111=F.
  - Any other pattern, or a decoded value >= MODULUS, is illegal.
- Acceptance: a stable pattern that differs from the last accepted pattern (or any stable pattern when none is accepted) is accepted exactly once.
  - Outputs register on the next edge.
  - Latency from the first edge at which the new pattern is present on a..g to the output update is STABLE_CYCLES+1 edges (3 at default).
- Glitches: a pattern held for fewer than STABLE_CYCLES samples is ignored entirely.
- FSM, WAIT state (no reference digit):
  - Legal accept: load digit, set digit_valid=1, go to TRACK, no step pulse.
  - Illegal accept: bad_pattern pulse, fault=1, stay in WAIT.
- FSM, TRACK state, with p = current digit and n = accepted digit:
  - n==(p+1) mod MODULUS: step_up pulse, up_cnt+1.
  - Else n==(p-1) mod MODULUS: step_down pulse, down_cnt+1.
  - Else: skip_err pulse, fault=1.
  - In all three cases digit=n and the state stays TRACK.
  - Up has priority (only matters when MODULUS=2).
  - Illegal accept: bad_pattern pulse, fault=1, digit_valid=0, digit holds, go to WAIT.
- Wrap-around: with MODULUS=4, 3->0 is step_up and 0->3 is step_down.
- Output rules:
  - At most one of step_up/step_down/skip_err/bad_pattern is high in any cycle.
  - Pulses are exactly 1 cycle wide.
  - fault clears only on reset.
  - Counters hold at all-ones and do not wrap.
- Reset mid-operation: immediate clear. The first digit accepted after release produces no step pulse.

Test Plan:
- Reset=0 for 2 cycles, then release with a..g=1111110 held -> after 3 edges digit=0, digit_valid=1, no pulses, fault=0.
- Drive 0,1,2,3,0 patterns, each held 4 cycles -> four step_up pulses (3->0 counts as up), up_cnt=4, down_cnt=0, fault=0.
- From digit 2, drive 3 (1111001) for 1 cycle, then back to 2 -> no accept, no pulses, digit stays 2.
- From digit 0, drive 0110011 (digit 4, >= MODULUS) held -> bad_pattern pulse, fault=1, digit_valid=0, digit=0. Then drive 1 -> digit=1, digit_valid=1, no step pulse.
- From digit 1, drive 3 held -> skip_err pulse, digit=3, fault=1. Then drive 2 -> step_down pulse, down_cnt=1.
- Mid-sequence, assert reset for 1 cycle with digit=2 and fault=1 -> all outputs 0 immediately. After release with pattern 3 held -> digit=3, no step pulse, up_cnt=0.

Source files
------------

// File: rtl/seg7_count_monitor.sv
// ---------------------------------------------------------------------------
// seg7_count_monitor
//
// Receiving end of a 7-segment display link. Registers the segment lines,
// waits until a pattern has been held for STABLE_CYCLES samples, decodes it
// back to a hex digit and classifies each digit change against the previous
// accepted digit as an up-step, a down-step or a skip. Up/down steps are
// counted in saturating counters. Illegal patterns and skips raise a sticky
// fault.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   a..g         segment lines, active-high
//   digit        last accepted valid digit
//   digit_valid  1 while digit reflects the currently accepted pattern
//   step_up      1-cycle pulse, accepted digit = previous + 1 (mod MODULUS)
//   step_down    1-cycle pulse, accepted digit = previous - 1 (mod MODULUS)
//   skip_err     1-cycle pulse, accepted digit neither up nor down
//   bad_pattern  1-cycle pulse, stable pattern is not a legal digit
//   fault        sticky, set on skip_err or bad_pattern, cleared by reset
//   up_cnt       saturating count of step_up pulses
//   down_cnt     saturating count of step_down pulses
//
// FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_WAIT  | no reference digit; next legal accept only loads digit
//   ST_TRACK | digit holds a reference; accepts are classified as steps
// ---------------------------------------------------------------------------
module seg7_count_monitor #(
    parameter int MODULUS       = 4,
    parameter int STABLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    input  logic             f,
    input  logic             g,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             step_up,
    output logic             step_down,
    output logic             skip_err,
    output logic             bad_pattern,
    output logic             fault,
    output logic [CNT_W-1:0] up_cnt,
    output logic [CNT_W-1:0] down_cnt
);

    typedef enum logic {
        ST_WAIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam logic [3:0] STABLE_N  = 4'(STABLE_CYCLES);
    localparam logic [3:0] MAX_DIGIT = 4'(MODULUS - 1);

    // Returns {known, value}; known=0 for patterns outside the hex font.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: return {1'b1, 4'h0};
            7'b0110000: return {1'b1, 4'h1};
            7'b1101101: return {1'b1, 4'h2};
            7'b1111001: return {1'b1, 4'h3};
            7'b0110011: return {1'b1, 4'h4};
            7'b1011011: return {1'b1, 4'h5};
            7'b1011111: return {1'b1, 4'h6};
            7'b1110000: return {1'b1, 4'h7};
            7'b1111111: return {1'b1, 4'h8};
            7'b1111011: return {1'b1, 4'h9};
            7'b1110111: return {1'b1, 4'hA};
            7'b0011111: return {1'b1, 4'hB};
            7'b1001110: return {1'b1, 4'hC};
            7'b0111101: return {1'b1, 4'hD};
            7'b1001111: return {1'b1, 4'hE};
            7'b1000111: return {1'b1, 4'hF};
            default:    return 5'b0_0000;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Input sampling and stability filter
    // -----------------------------------------------------------------------
    logic [6:0] seg_in;
    logic [6:0] seg_q;
    logic [3:0] stab_cnt;

    assign seg_in = {a, b, c, d, e, f, g};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q    <= 7'b0;
            stab_cnt <= 4'd0;
        end else begin
            seg_q <= seg_in;
            if (seg_in != seg_q) begin
                stab_cnt <= 4'd1;
            end else if (stab_cnt != STABLE_N) begin
                stab_cnt <= stab_cnt + 4'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Acceptance
    // The last accepted pattern is remembered even when it was illegal, so a
    // held bad pattern reports once and a short glitch that returns to the
    // accepted pattern is not re-accepted.
    // -----------------------------------------------------------------------
    logic [6:0] acc_pat;
    logic       acc_have;
    logic       stable;
    logic       accept;
    logic [4:0] dec;
    logic [3:0] dec_val;
    logic       dec_legal;

    assign stable    = (stab_cnt == STABLE_N);
    assign accept    = stable && (!acc_have || (seg_q != acc_pat));
    assign dec       = decode(seg_q);
    assign dec_val   = dec[3:0];
    assign dec_legal = dec[4] && (dec_val <= MAX_DIGIT);

    // -----------------------------------------------------------------------
    // Classification FSM
    // -----------------------------------------------------------------------
    state_t           state, state_d;
    logic [3:0]       digit_d;
    logic             valid_d;
    logic             up_d, down_d, skip_d, bad_d;
    logic             fault_d;
    logic [CNT_W-1:0] up_cnt_d, down_cnt_d;
    logic [6:0]       acc_pat_d;
    logic             acc_have_d;
    logic [3:0]       up_val, dn_val;

    assign up_val = (digit == MAX_DIGIT) ? 4'd0 : digit + 4'd1;
    assign dn_val = (digit == 4'd0) ? MAX_DIGIT : digit - 4'd1;

    always_comb begin
        state_d    = state;
        digit_d    = digit;
        valid_d    = digit_valid;
        up_d       = 1'b0;
        down_d     = 1'b0;
        skip_d     = 1'b0;
        bad_d      = 1'b0;
        fault_d    = fault;
        up_cnt_d   = up_cnt;
        down_cnt_d = down_cnt;
        acc_pat_d  = acc_pat;
        acc_have_d = acc_have;

        if (accept) begin
            acc_pat_d  = seg_q;
            acc_have_d = 1'b1;
            case (state)
                ST_WAIT: begin
                    if (dec_legal) begin
                        digit_d = dec_val;
                        valid_d = 1'b1;
                        state_d = ST_TRACK;
                    end else begin
                        bad_d   = 1'b1;
                        fault_d = 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (dec_legal) begin
                        digit_d = dec_val;
                        // Up checked first: with MODULUS=2 both match.
                        if (dec_val == up_val) begin
                            up_d = 1'b1;
                            if (up_cnt != '1) up_cnt_d = up_cnt + CNT_W'(1);
                        end else if (dec_val == dn_val) begin
                            down_d = 1'b1;
                            if (down_cnt != '1) down_cnt_d = down_cnt + CNT_W'(1);
                        end else begin
                            skip_d  = 1'b1;
                            fault_d = 1'b1;
                        end
                    end else begin
                        bad_d   = 1'b1;
                        fault_d = 1'b1;
                        valid_d = 1'b0;
                        state_d = ST_WAIT;
                    end
                end
                default: state_d = ST_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_WAIT;
            digit       <= 4'd0;
            digit_valid <= 1'b0;
            step_up     <= 1'b0;
            step_down   <= 1'b0;
            skip_err    <= 1'b0;
            bad_pattern <= 1'b0;
            fault       <= 1'b0;
            up_cnt      <= '0;
            down_cnt    <= '0;
            acc_pat     <= 7'b0;
            acc_have    <= 1'b0;
        end else begin
            state       <= state_d;
            digit       <= digit_d;
            digit_valid <= valid_d;
            step_up     <= up_d;
            step_down   <= down_d;
            skip_err    <= skip_d;
            bad_pattern <= bad_d;
            fault       <= fault_d;
            up_cnt      <= up_cnt_d;
            down_cnt    <= down_cnt_d;
            acc_pat     <= acc_pat_d;
            acc_have    <= acc_have_d;
        end
    end

endmodule

// File: tb/tb_seg7_count_monitor.sv
module tb_seg7_count_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] segs = 7'b1111110;
    logic [3:0] digit;
    logic       digit_valid, step_up, step_down, skip_err, bad_pattern, fault;
    logic [7:0] up_cnt, down_cnt;

    int assertions = 0;
    int failures   = 0;
    int n_up, n_down, n_skip, n_bad;
    int onehot_viol = 0;

    seg7_count_monitor #(.MODULUS(4), .STABLE_CYCLES(2), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .a(segs[6]), .b(segs[5]), .c(segs[4]), .d(segs[3]),
        .e(segs[2]), .f(segs[1]), .g(segs[0]),
        .digit(digit), .digit_valid(digit_valid),
        .step_up(step_up), .step_down(step_down),
        .skip_err(skip_err), .bad_pattern(bad_pattern),
        .fault(fault), .up_cnt(up_cnt), .down_cnt(down_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            default: return 7'b0000000;
        endcase
    endfunction

    // Drive a pattern (called at a falling edge) and hold it for n cycles,
    // tallying the pulses seen at each falling edge.
    task automatic hold(input logic [6:0] p, input int n);
        segs   = p;
        n_up   = 0; n_down = 0; n_skip = 0; n_bad = 0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            n_up   += int'(step_up);
            n_down += int'(step_down);
            n_skip += int'(skip_err);
            n_bad  += int'(bad_pattern);
            if ((int'(step_up) + int'(step_down) + int'(skip_err) + int'(bad_pattern)) > 1)
                onehot_viol++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        segs  = seg_of(0);
        repeat (2) @(negedge clk);
        assertions++; if (digit_valid !== 1'b0 || digit !== 4'd0) begin failures++; $display("FAIL reset_digit: valid=%b digit=%0d, required 0/0", digit_valid, digit); end
        assertions++; if (fault !== 1'b0 || up_cnt !== 8'd0 || down_cnt !== 8'd0) begin failures++; $display("FAIL reset_regs: fault=%b up=%0d down=%0d, required 0", fault, up_cnt, down_cnt); end
        reset = 1'b1;
        hold(seg_of(0), 2);
        assertions++; if (digit_valid !== 1'b0) begin failures++; $display("FAIL latency_early: valid=%b after 2 edges, required 0", digit_valid); end
        hold(seg_of(0), 1);
        assertions++; if (digit_valid !== 1'b1 || digit !== 4'd0) begin failures++; $display("FAIL first_accept: valid=%b digit=%0d, required 1/0", digit_valid, digit); end
        assertions++; if (n_up + n_down + n_skip + n_bad !== 0 || fault !== 1'b0) begin failures++; $display("FAIL first_accept_pulses: pulses=%0d fault=%b, required 0/0", n_up + n_down + n_skip + n_bad, fault); end
    endtask

    task automatic test_count_up();
        int ups = 0, others = 0;
        hold(seg_of(0), 4); ups += n_up; others += n_down + n_skip + n_bad;
        for (int v = 1; v <= 4; v++) begin
            hold(seg_of(v % 4), 4);
            ups += n_up; others += n_down + n_skip + n_bad;
        end
        assertions++; if (ups !== 4 || others !== 0) begin failures++; $display("FAIL count_up_pulses: up=%0d other=%0d, required 4/0", ups, others); end
        assertions++; if (up_cnt !== 8'd4 || down_cnt !== 8'd0) begin failures++; $display("FAIL count_up_cnt: up=%0d down=%0d, required 4/0", up_cnt, down_cnt); end
        assertions++; if (digit !== 4'd0 || fault !== 1'b0) begin failures++; $display("FAIL count_up_digit: digit=%0d fault=%b, required 0/0", digit, fault); end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        hold(seg_of(1), 4);
        hold(seg_of(2), 4);
        assertions++; if (digit !== 4'd2 || up_cnt !== 8'd6) begin failures++; $display("FAIL glitch_setup: digit=%0d up=%0d, required 2/6", digit, up_cnt); end
        hold(seg_of(3), 1); pulses += n_up + n_down + n_skip + n_bad;
        hold(seg_of(2), 4); pulses += n_up + n_down + n_skip + n_bad;
        assertions++; if (pulses !== 0 || digit !== 4'd2 || up_cnt !== 8'd6) begin failures++; $display("FAIL glitch_ignored: pulses=%0d digit=%0d up=%0d, required 0/2/6", pulses, digit, up_cnt); end
    endtask

    task automatic test_bad_pattern();
        hold(seg_of(3), 4);
        hold(seg_of(0), 4);
        hold(seg_of(4), 5);
        assertions++; if (n_bad !== 1 || n_up + n_down + n_skip !== 0) begin failures++; $display("FAIL bad_pulse: bad=%0d other=%0d, required 1/0", n_bad, n_up + n_down + n_skip); end
        assertions++; if (fault !== 1'b1 || digit_valid !== 1'b0 || digit !== 4'd0) begin failures++; $display("FAIL bad_state: fault=%b valid=%b digit=%0d, required 1/0/0", fault, digit_valid, digit); end
        hold(seg_of(1), 4);
        assertions++; if (digit_valid !== 1'b1 || digit !== 4'd1) begin failures++; $display("FAIL bad_recover: valid=%b digit=%0d, required 1/1", digit_valid, digit); end
        assertions++; if (n_up + n_down + n_skip + n_bad !== 0 || up_cnt !== 8'd8) begin failures++; $display("FAIL bad_recover_pulses: pulses=%0d up=%0d, required 0/8", n_up + n_down + n_skip + n_bad, up_cnt); end
    endtask

    task automatic test_skip_down();
        hold(seg_of(3), 4);
        assertions++; if (n_skip !== 1 || n_up + n_down + n_bad !== 0 || digit !== 4'd3) begin failures++; $display("FAIL skip: skip=%0d other=%0d digit=%0d, required 1/0/3", n_skip, n_up + n_down + n_bad, digit); end
        assertions++; if (fault !== 1'b1) begin failures++; $display("FAIL skip_fault: fault=%b, required 1", fault); end
        hold(seg_of(2), 4);
        assertions++; if (n_down !== 1 || down_cnt !== 8'd1 || digit !== 4'd2) begin failures++; $display("FAIL step_down: pulses=%0d down=%0d digit=%0d, required 1/1/2", n_down, down_cnt, digit); end
        hold(seg_of(3), 4);
        hold(seg_of(0), 4);
        hold(seg_of(3), 4);
        assertions++; if (n_down !== 1 || down_cnt !== 8'd2 || digit !== 4'd3) begin failures++; $display("FAIL wrap_down: pulses=%0d down=%0d digit=%0d, required 1/2/3", n_down, down_cnt, digit); end
        hold(seg_of(2), 4);
        assertions++; if (fault !== 1'b1 || down_cnt !== 8'd3) begin failures++; $display("FAIL fault_sticky: fault=%b down=%0d, required 1/3", fault, down_cnt); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        segs  = seg_of(3);
        #1;
        assertions++; if (digit !== 4'd0 || digit_valid !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL mid_reset: digit=%0d valid=%b fault=%b, required 0/0/0", digit, digit_valid, fault); end
        assertions++; if (up_cnt !== 8'd0 || down_cnt !== 8'd0) begin failures++; $display("FAIL mid_reset_cnt: up=%0d down=%0d, required 0/0", up_cnt, down_cnt); end
        @(negedge clk);
        reset = 1'b1;
        hold(seg_of(3), 4);
        assertions++; if (digit !== 4'd3 || digit_valid !== 1'b1) begin failures++; $display("FAIL mid_release: digit=%0d valid=%b, required 3/1", digit, digit_valid); end
        assertions++; if (n_up + n_down + n_skip + n_bad !== 0 || up_cnt !== 8'd0) begin failures++; $display("FAIL mid_release_pulses: pulses=%0d up=%0d, required 0/0", n_up + n_down + n_skip + n_bad, up_cnt); end
    endtask

    task automatic test_saturate();
        int v = 3;
        int ups = 0;
        for (int i = 0; i < 260; i++) begin
            v = (v + 1) % 4;
            hold(seg_of(v), 3);
            ups += n_up;
        end
        assertions++; if (ups !== 260) begin failures++; $display("FAIL sat_pulses: up pulses=%0d, required 260", ups); end
        assertions++; if (up_cnt !== 8'hFF || down_cnt !== 8'd0 || fault !== 1'b0) begin failures++; $display("FAIL sat_cnt: up=%0d down=%0d fault=%b, required 255/0/0", up_cnt, down_cnt, fault); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_glitch();
        test_bad_pattern();
        test_skip_down();
        test_reset_mid();
        test_saturate();
        assertions++; if (onehot_viol !== 0) begin failures++; $display("FAIL pulse_onehot: %0d cycles with multiple pulses, required 0", onehot_viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
